// File: rtl/fetch_stage_pkg.sv
// Shared constants and small helpers for the IF stage of the pipelined MIPS core.
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEF   = 32'h0040_0000;  // text segment base
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h8000_0180;  // general exception vector
    localparam logic [31:0] NOP            = 32'h0000_0000;  // sll $0,$0,0

    // Source of the next fetch PC
    typedef enum logic [1:0] {
        NPC_SEQ   = 2'd0,
        NPC_HOLD  = 2'd1,
        NPC_REDIR = 2'd2,
        NPC_EXC   = 2'd3
    } npc_sel_e;

    // Action applied to the IF/ID register on the next edge
    typedef enum logic [1:0] {
        IFID_LOAD   = 2'd0,
        IFID_HOLD   = 2'd1,
        IFID_BUBBLE = 2'd2
    } ifid_op_e;

    // Instruction addresses must be word aligned
    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// 32-bit PC register with load enable and a parameterised asynchronous reset value.
module fetch_pc_reg #(
    parameter logic [31:0] RST_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [31:0] d,
    output logic [31:0] q
);

    logic [31:0] pc_q;

    // PC storage: returns to RST_VAL immediately on reset, loads d when enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RST_VAL;
        end else if (en) begin
            pc_q <= d;
        end
    end

    assign q = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, addresses the instruction ROM, loads the IF/ID register,
// flags misaligned redirects and counts instructions handed to decode.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,          // active-low, asynchronous
    input  logic             stall,
    input  logic             flush,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    input  logic             except_req,
    output logic [29:0]      imem_addr,
    input  logic [31:0]      imem_data,
    output logic [31:0]      PC,
    output logic [31:0]      inst_IF,
    output logic [31:0]      pc4_ID,
    output logic [31:0]      inst_ID,
    output logic             valid_ID,
    output logic             misalign_exc,
    output logic [CNT_W-1:0] fetch_count
);

    // Saturating increment: the counter sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic [31:0]      pc_q;
    logic [31:0]      pc_d;
    logic             pc_en;
    logic [31:0]      pc_plus4;
    logic             misalign_d;
    logic             misalign_q;
    npc_sel_e         npc_sel;
    ifid_op_e         ifid_op;

    logic [31:0]      pc4_id_q, pc4_id_d;
    logic [31:0]      inst_id_q, inst_id_d;
    logic             valid_id_q, valid_id_d;
    logic [CNT_W-1:0] fetch_count_q, fetch_count_d;

    // Wraps modulo 2^32; no carry is reported
    assign pc_plus4   = pc_q + 32'd4;
    assign misalign_d = redirect_valid && is_misaligned(redirect_pc);

    // Priority decode: exceptions beat redirects, redirects beat stall
    always_comb begin
        npc_sel = NPC_SEQ;
        ifid_op = IFID_LOAD;

        if (except_req || misalign_d) begin
            npc_sel = NPC_EXC;
        end else if (redirect_valid) begin
            npc_sel = NPC_REDIR;
        end else if (stall) begin
            npc_sel = NPC_HOLD;
        end

        if (flush || except_req || misalign_d) begin
            ifid_op = IFID_BUBBLE;
        end else if (stall) begin
            ifid_op = IFID_HOLD;
        end
    end

    // Next-PC mux; a held PC simply disables the register
    always_comb begin
        pc_d  = pc_plus4;
        pc_en = (npc_sel != NPC_HOLD);
        case (npc_sel)
            NPC_EXC:   pc_d = EXC_VECTOR;
            NPC_REDIR: pc_d = redirect_pc;
            NPC_HOLD:  pc_d = pc_q;
            default:   pc_d = pc_plus4;
        endcase
    end

    fetch_pc_reg #(
        .RST_VAL (RESET_PC)
    ) u_pc_reg (
        .clk   (clk),
        .rst_n (reset),
        .en    (pc_en),
        .d     (pc_d),
        .q     (pc_q)
    );

    // IF/ID next state and the retired-fetch count that tracks valid loads
    always_comb begin
        pc4_id_d      = pc4_id_q;
        inst_id_d     = inst_id_q;
        valid_id_d    = valid_id_q;
        fetch_count_d = fetch_count_q;
        case (ifid_op)
            IFID_BUBBLE: begin
                pc4_id_d   = 32'h0;
                inst_id_d  = NOP;
                valid_id_d = 1'b0;
            end
            IFID_LOAD: begin
                pc4_id_d      = pc_plus4;
                inst_id_d     = imem_data;
                valid_id_d    = 1'b1;
                fetch_count_d = sat_inc(fetch_count_q);
            end
            default: ;
        endcase
    end

    // IF/ID register, misalign pulse and counter; all clear asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc4_id_q      <= 32'h0;
            inst_id_q     <= NOP;
            valid_id_q    <= 1'b0;
            misalign_q    <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            pc4_id_q      <= pc4_id_d;
            inst_id_q     <= inst_id_d;
            valid_id_q    <= valid_id_d;
            misalign_q    <= misalign_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_addr    = pc_q[31:2];
    assign PC           = pc_q;
    assign inst_IF      = reset ? imem_data : NOP;
    assign pc4_ID       = pc4_id_q;
    assign inst_ID      = inst_id_q;
    assign valid_ID     = valid_id_q;
    assign misalign_exc = misalign_q;
    assign fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by randomized traffic, all
// compared against a cycle-level behavioural model of the IF stage.
module tb_fetch_stage;

    localparam int          CW      = 4;
    localparam logic [31:0] RST_PC  = 32'h0040_0000;
    localparam logic [31:0] EXC_VEC = 32'h8000_0180;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall, flush, redirect_valid, except_req;
    logic [31:0]   redirect_pc;
    logic [29:0]   imem_addr;
    logic [31:0]   imem_data;
    logic [31:0]   PC, inst_IF, pc4_ID, inst_ID;
    logic          valid_ID, misalign_exc;
    logic [CW-1:0] fetch_count;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    logic [31:0] m_pc, m_pc4, m_inst;
    logic        m_valid, m_mis;
    int          m_cnt;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [29:0] a);
        return {a, 2'b11} ^ 32'h5A5A_C3C3;
    endfunction

    assign imem_data = rom(imem_addr);

    fetch_stage #(
        .RESET_PC   (RST_PC),
        .EXC_VECTOR (EXC_VEC),
        .CNT_W      (CW)
    ) dut (
        .clk            (clk),
        .reset          (rst_n),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .except_req     (except_req),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .PC             (PC),
        .inst_IF        (inst_IF),
        .pc4_ID         (pc4_ID),
        .inst_ID        (inst_ID),
        .valid_ID       (valid_ID),
        .misalign_exc   (misalign_exc),
        .fetch_count    (fetch_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = RST_PC;
        m_pc4   = 32'h0;
        m_inst  = 32'h0;
        m_valid = 1'b0;
        m_mis   = 1'b0;
        m_cnt   = 0;
    endtask

    // One clock edge of the IF stage, straight from the priority rules
    task automatic model_edge();
        logic        bad;
        logic        squash;
        logic [31:0] seq;
        bad    = redirect_valid && (redirect_pc[1:0] != 2'b00);
        squash = flush || except_req || bad;
        seq    = m_pc + 32'd4;
        if (squash) begin
            m_pc4 = 0; m_inst = 0; m_valid = 0;
        end else if (!stall) begin
            m_pc4 = seq; m_inst = rom(m_pc[31:2]); m_valid = 1;
            if (m_cnt < (1 << CW) - 1) m_cnt++;
        end
        if (except_req || bad)   m_pc = EXC_VEC;
        else if (redirect_valid) m_pc = redirect_pc;
        else if (!stall)         m_pc = seq;
        m_mis = bad;
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".pc"},    PC, m_pc);
        check_eq({tag, ".addr"},  32'(imem_addr), 32'(m_pc[31:2]));
        check_eq({tag, ".instIF"}, inst_IF, rst_n ? rom(m_pc[31:2]) : 32'h0);
        check_eq({tag, ".pc4"},   pc4_ID, m_pc4);
        check_eq({tag, ".inst"},  inst_ID, m_inst);
        check_eq({tag, ".valid"}, 32'(valid_ID), 32'(m_valid));
        check_eq({tag, ".mis"},   32'(misalign_exc), 32'(m_mis));
        check_eq({tag, ".cnt"},   32'(fetch_count), 32'(m_cnt));
    endtask

    task automatic drive(input logic st, input logic fl, input logic rv,
                         input logic [31:0] rpc, input logic ex);
        stall = st; flush = fl; redirect_valid = rv; redirect_pc = rpc; except_req = ex;
    endtask

    task automatic tick(input string tag);
        if (rst_n) model_edge();
        else       model_reset();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 32'h0, 0);
        model_reset();

        // Reset held for three cycles
        repeat (3) tick("rst");
        check_eq("rst_pc", PC, RST_PC);
        check_eq("rst_valid", 32'(valid_ID), 32'h0);
        rst_n = 1'b1;
        #1;
        check_eq("rel_valid", 32'(valid_ID), 32'h0);
        check_eq("rel_instIF", inst_IF, rom(30'h0010_0000));

        // Sequential fetch after release
        tick("seq1");
        check_eq("seq1_pc", PC, 32'h0040_0004);
        check_eq("seq1_pc4", pc4_ID, 32'h0040_0004);
        check_eq("seq1_valid", 32'(valid_ID), 32'h1);
        tick("seq2");
        check_eq("seq2_pc", PC, 32'h0040_0008);
        tick("seq3");
        check_eq("seq3_cnt", 32'(fetch_count), 32'd3);
        check_eq("seq3_pc", PC, 32'h0040_000C);

        // Two-cycle stall at 0x0040000C
        drive(1, 0, 0, 32'h0, 0);
        tick("stall1");
        tick("stall2");
        check_eq("stall_pc", PC, 32'h0040_000C);
        check_eq("stall_inst", inst_ID, rom(30'h0010_0002));
        check_eq("stall_cnt", 32'(fetch_count), 32'd3);
        drive(0, 0, 0, 32'h0, 0);
        tick("resume");
        check_eq("resume_pc", PC, 32'h0040_0010);
        repeat (4) tick("run");
        check_eq("run_pc", PC, 32'h0040_0020);

        // Taken redirect with flush
        drive(0, 1, 1, 32'h0040_0100, 0);
        tick("redir");
        check_eq("redir_pc", PC, 32'h0040_0100);
        check_eq("redir_inst", inst_ID, 32'h0);
        check_eq("redir_valid", 32'(valid_ID), 32'h0);
        drive(0, 0, 0, 32'h0, 0);
        tick("redir2");
        check_eq("redir2_inst", inst_ID, rom(30'h0010_0040));

        // Misaligned redirect vectors to the exception handler
        drive(0, 0, 1, 32'h0040_0102, 0);
        tick("mis");
        check_eq("mis_pc", PC, EXC_VEC);
        check_eq("mis_exc", 32'(misalign_exc), 32'h1);
        check_eq("mis_valid", 32'(valid_ID), 32'h0);
        drive(0, 0, 0, 32'h0, 0);
        tick("mis2");
        check_eq("mis2_exc", 32'(misalign_exc), 32'h0);

        // Redirect beats stall
        drive(1, 0, 1, 32'h0040_0200, 0);
        tick("stredir");
        check_eq("stredir_pc", PC, 32'h0040_0200);

        // PC wraps past the top of the address space
        drive(0, 0, 1, 32'hFFFF_FFFC, 0);
        tick("wrap1");
        drive(0, 0, 0, 32'h0, 0);
        tick("wrap2");
        check_eq("wrap_pc", PC, 32'h0000_0000);

        // Counter saturates at all-ones
        repeat (20) tick("sat");
        check_eq("sat_cnt", 32'(fetch_count), 32'hF);

        // Asynchronous reset in the middle of a stall at 0x00400040
        rst_n = 1'b0;
        tick("rst2");
        rst_n = 1'b1;
        repeat (16) tick("adv");
        check_eq("adv_pc", PC, 32'h0040_0040);
        drive(1, 0, 0, 32'h0, 0);
        tick("midst");
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("arst");
        check_eq("arst_pc", PC, RST_PC);
        check_eq("arst_cnt", 32'(fetch_count), 32'h0);
        drive(0, 0, 0, 32'h0, 0);
        tick("arst_hold");
        rst_n = 1'b1;

        // Randomized traffic, with occasional asynchronous reset pulses
        for (int i = 0; i < 400; i++) begin
            logic [31:0] rpc;
            rpc = $urandom;
            if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 5) == 0, rpc, $urandom_range(0, 19) == 0);
            tick("rnd");
            if ($urandom_range(0, 49) == 0) begin
                #2;
                rst_n = 1'b0;
                #1;
                model_reset();
                check_all("rnd_arst");
                #1;
                rst_n = 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
